// File: rtl/vector_aes_pkg.sv
// Shared definitions for the vector AES unit: op codes, FSM states, S-box tables
// and the GF(2^8) / state-permutation helpers used by the single-cycle ops.
// Pure package: no ports, no state.
package vector_aes_pkg;

  typedef enum logic [3:0] {
    OP_XOR             = 4'b0000,
    OP_ROT             = 4'b0001,
    OP_SUBBYTES        = 4'b1000,
    OP_INV_SUBBYTES    = 4'b1001,
    OP_SHIFTROWS       = 4'b1010,
    OP_MIX_COLUMNS     = 4'b1011,
    OP_KEYSCHE_XOR     = 4'b1100,
    OP_INV_SHIFTROWS   = 4'b1101,
    OP_INV_MIX_COLUMNS = 4'b1110
  } valu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SBOX,
    ST_DONE
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Byte r+4c is row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
    return o;
  endfunction

  // Column byte 0 (bits [7:0]) is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = col;
    return {gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02),
            a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
            a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
            gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = col;
    return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box, forward or inverse selected by inv.
// Purely combinational, zero latency; no handshake.
// Ports: in_byte (8) -> out_byte (8), inv selects the inverse table.
module aes_sbox
  import vector_aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  assign out_byte = inv ? SBOX_INV[in_byte] : SBOX_FWD[in_byte];

endmodule

// File: rtl/vector_aes_unit.sv
// Vector AES execution unit over NUM_LANES independent 128-bit lanes.
// Latency 1 for all ops except (Inv)SubBytes, which takes 16/SBOX_PER_CYCLE cycles.
// One op in flight: in_ready only in IDLE; result held with out_valid until out_ready.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_op/in_op1/in_op2 request side;
//        out_valid/out_ready/out_result/out_illegal response side.
module vector_aes_unit
  import vector_aes_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [128*NUM_LANES-1:0] in_op1,
  input  logic [128*NUM_LANES-1:0] in_op2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [128*NUM_LANES-1:0] out_result,
  output logic                     out_illegal
);

  localparam int W      = 128 * NUM_LANES;
  localparam int NCHUNK = 16 / SBOX_PER_CYCLE;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     res_q, res_d;
  logic             ill_q, ill_d;

  logic             is_sbox_op;
  logic [W-1:0]     alu_res;
  logic             alu_ill;

  logic [W-1:0]     sbox_src;
  logic [CNT_W-1:0] chunk_sel;
  logic             sbox_inv;
  logic [W-1:0]     sub_merged;
  logic [7:0]       sbox_in  [NUM_LANES][SBOX_PER_CYCLE];
  logic [7:0]       sbox_out [NUM_LANES][SBOX_PER_CYCLE];

  assign is_sbox_op = (in_op == OP_SUBBYTES) || (in_op == OP_INV_SUBBYTES);

  // Single-cycle ops, computed straight from the request so the result is
  // captured at the accept edge.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      case (in_op)
        OP_XOR:
          alu_res[128*l +: 128] = in_op1[128*l +: 128] ^ in_op2[128*l +: 128];
        OP_ROT:
          for (int k = 0; k < 4; k++)
            alu_res[128*l+32*k +: 32] = {in_op1[128*l+32*k +: 8], in_op1[128*l+32*k+8 +: 24]};
        OP_SHIFTROWS:
          alu_res[128*l +: 128] = shift_rows(in_op1[128*l +: 128]);
        OP_INV_SHIFTROWS:
          alu_res[128*l +: 128] = inv_shift_rows(in_op1[128*l +: 128]);
        OP_MIX_COLUMNS:
          for (int k = 0; k < 4; k++)
            alu_res[128*l+32*k +: 32] = mix_column(in_op1[128*l+32*k +: 32]);
        OP_INV_MIX_COLUMNS:
          for (int k = 0; k < 4; k++)
            alu_res[128*l+32*k +: 32] = inv_mix_column(in_op1[128*l+32*k +: 32]);
        OP_KEYSCHE_XOR: begin
          // Chain: each new word folds in the previously produced one.
          alu_res[128*l +: 32] = in_op1[128*l +: 32] ^ in_op2[128*l +: 32];
          for (int k = 1; k < 4; k++)
            alu_res[128*l+32*k +: 32] = in_op1[128*l+32*k +: 32] ^ alu_res[128*l+32*(k-1) +: 32];
        end
        OP_SUBBYTES, OP_INV_SUBBYTES: ;
        default:
          alu_ill = 1'b1;
      endcase
    end
  end

  // The first chunk is substituted straight from in_op1 at accept, later
  // chunks from the working register; this keeps SubBytes latency at
  // exactly NCHUNK cycles.
  always_comb begin
    sbox_src   = (state_q == ST_IDLE) ? in_op1 : res_q;
    chunk_sel  = (state_q == ST_IDLE) ? '0 : cnt_q;
    sbox_inv   = (state_q == ST_IDLE) ? (in_op == OP_INV_SUBBYTES) : (op_q == OP_INV_SUBBYTES);
    sub_merged = sbox_src;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < SBOX_PER_CYCLE; s++) begin
        sbox_in[l][s] = sbox_src[128*l + 8*(int'(chunk_sel)*SBOX_PER_CYCLE + s) +: 8];
        sub_merged[128*l + 8*(int'(chunk_sel)*SBOX_PER_CYCLE + s) +: 8] = sbox_out[l][s];
      end
    end
  end

  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    for (genvar gs = 0; gs < SBOX_PER_CYCLE; gs++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sbox_in[gl][gs]),
        .inv      (sbox_inv),
        .out_byte (sbox_out[gl][gs])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          if (is_sbox_op) begin
            res_d = sub_merged;
            ill_d = 1'b0;
            if (NCHUNK == 1) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              state_d = ST_SBOX;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            res_d   = alu_res;
            ill_d   = alu_ill;
            state_d = ST_DONE;
          end
        end
      end
      ST_SBOX: begin
        res_d = sub_merged;
        if (cnt_q == LAST_CHUNK) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'b0000;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = res_q;
  assign out_illegal = ill_q;

endmodule
